// File: rtl/conv_drain_pkg.sv
// Shared types and constants for the conv result drain streamer.
package conv_drain_pkg;

    // Controller states, in the order a run walks through them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        DRAIN     = 3'd3,
        FLUSH     = 3'd4,
        DONE      = 3'd5
    } drain_state_e;

    localparam int DEF_NUM_ELEM = 32768;
    localparam int DEF_ELEM_W   = 4;
    localparam int DEF_PACK     = 8;
    localparam int WORD_W       = DEF_PACK * DEF_ELEM_W;
    localparam int NUM_WORDS    = DEF_NUM_ELEM / DEF_PACK;
    localparam int FIFO_DEPTH   = 2;

    // Output-FIFO entries that are committed: stored words plus groups still in flight.
    function automatic logic [2:0] occupancy(input logic [1:0] fifo_count,
                                             input logic [1:0] reserved);
        return {1'b0, fifo_count} + {1'b0, reserved};
    endfunction

endpackage

// File: rtl/drain_word_fifo.sv
// Two-entry FIFO of {tlast, packed word}; the head entry drives the output stream directly.
module drain_word_fifo
    import conv_drain_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [1:0] DEPTH_CNT = 2'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_data_r [FIFO_DEPTH];
    logic              mem_last_r [FIFO_DEPTH];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == 2'd0);
    assign count     = count_r;
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign out_data  = mem_data_r[rd_ptr_r];
    assign out_last  = mem_last_r[rd_ptr_r] & ~empty;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, cleared on reset so the idle stream shows zeros.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= '0;
                mem_last_r[i] <= 1'b0;
            end
        end else if (do_push_s) begin
            mem_data_r[wr_ptr_r] <= push_data;
            mem_last_r[wr_ptr_r] <= push_last;
        end
    end

endmodule

// File: rtl/conv_result_drain_streamer.sv
// Starts the accelerator, waits for done, then reads every result element, packs PACK
// elements per word and streams the words out losslessly with tlast on the final word.
module conv_result_drain_streamer
    import conv_drain_pkg::*;
#(
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int PACK     = DEF_PACK,
    parameter int ADDR_W   = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     go,
    output logic                     busy,
    output logic                     acc_start,
    input  logic                     acc_done,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [ELEM_W-1:0]        rd_data,
    output logic [PACK*ELEM_W-1:0]   m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     drain_done
);

    localparam int DATA_W = PACK * ELEM_W;
    localparam int LANE_W = $clog2(PACK);
    localparam int CNT_W  = $clog2(NUM_ELEM + 1);
    localparam logic [CNT_W-1:0]  ELEM_TOTAL = CNT_W'(NUM_ELEM);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_ELEM - 1);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(PACK - 1);

    if ((NUM_ELEM % PACK) != 0) begin : g_bad_num_elem
        $error("NUM_ELEM must be a multiple of PACK");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("RD_LAT must be at least 1");
    end
    if (PACK < 2) begin : g_bad_pack
        $error("PACK must be at least 2");
    end

    drain_state_e      state_r;
    drain_state_e      state_nxt;
    logic              busy_r;
    logic              acc_start_r;
    logic              drain_done_r;

    // Read issue: rd_addr_r/issue_r describe the read presented this cycle.
    logic [ADDR_W-1:0] rd_addr_r;
    logic              issue_r;
    logic [LANE_W-1:0] issue_lane_r;
    logic [CNT_W-1:0]  elem_cnt_r;
    logic [1:0]        resv_r;
    logic [CNT_W-1:0]  cnt_after_s;
    logic [LANE_W-1:0] lane_after_s;
    logic              issue_nxt_s;
    logic              group_start_s;
    logic              last_issue_s;
    logic [2:0]        fifo_cnt_nxt_s;
    logic [1:0]        resv_rel_s;
    logic              go_accept_s;

    // Read-return pipeline and packing.
    logic [RD_LAT-1:0] vld_pipe_r;
    logic [RD_LAT-1:0] last_pipe_r;
    logic [LANE_W-1:0] lane_pipe_r [RD_LAT];
    logic [DATA_W-1:0] pack_r;
    logic              push_pend_r;
    logic              push_last_r;
    logic              cap_s;
    logic [LANE_W-1:0] cap_lane_s;

    // Output FIFO interface.
    logic              fifo_push_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [1:0]        fifo_count_s;
    logic [DATA_W-1:0] fifo_data_s;
    logic              fifo_last_s;
    logic              pop_s;

    assign busy         = busy_r;
    assign acc_start    = acc_start_r;
    assign drain_done   = drain_done_r;
    assign rd_addr      = rd_addr_r;
    assign m_tdata      = fifo_data_s;
    assign m_tlast      = fifo_last_s;
    assign m_tvalid     = ~fifo_empty_s;
    assign pop_s        = ~fifo_empty_s & m_tready;
    assign go_accept_s  = (state_r == IDLE) & go;
    assign last_issue_s = issue_r & (rd_addr_r == LAST_ADDR);
    assign cap_s        = vld_pipe_r[RD_LAT-1];
    assign cap_lane_s   = lane_pipe_r[RD_LAT-1];
    assign fifo_push_s  = push_pend_r & (~fifo_full_s | pop_s);

    // Controller next-state: one start pulse, wait for done, drain, flush, report.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (go) begin
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (acc_done) begin
                    state_nxt = DRAIN;
                end else begin
                    state_nxt = WAIT_DONE;
                end
            end
            DRAIN: begin
                if (last_issue_s) begin
                    state_nxt = FLUSH;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            FLUSH: begin
                if (pop_s && fifo_last_s) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = FLUSH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Decide next cycle's read: groups continue back to back, and a new group needs a free
    // output entry counting this cycle's push/pop and the groups still being read.
    always_comb begin
        cnt_after_s  = elem_cnt_r;
        lane_after_s = issue_lane_r;
        if (issue_r) begin
            cnt_after_s = elem_cnt_r + CNT_W'(1);
            if (issue_lane_r == LAST_LANE) begin
                lane_after_s = '0;
            end else begin
                lane_after_s = issue_lane_r + LANE_W'(1);
            end
        end else begin
            cnt_after_s  = elem_cnt_r;
            lane_after_s = issue_lane_r;
        end
        fifo_cnt_nxt_s = {1'b0, fifo_count_s} + {2'b00, fifo_push_s} - {2'b00, pop_s};
        resv_rel_s     = resv_r - {1'b0, fifo_push_s};
        group_start_s  = (lane_after_s == '0);
        issue_nxt_s    = (state_nxt == DRAIN) && (cnt_after_s < ELEM_TOTAL) &&
                         (!group_start_s ||
                          (occupancy(fifo_cnt_nxt_s[1:0], resv_rel_s) < 3'd2));
    end

    // Controller state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Status outputs registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r       <= 1'b0;
            acc_start_r  <= 1'b0;
            drain_done_r <= 1'b0;
        end else begin
            busy_r       <= (state_nxt == START) || (state_nxt == WAIT_DONE) ||
                            (state_nxt == DRAIN) || (state_nxt == FLUSH);
            acc_start_r  <= (state_nxt == START);
            drain_done_r <= (state_nxt == DONE);
        end
    end

    // Read address and element/lane counters; rd_addr only moves when a read is issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr_r    <= '0;
            issue_r      <= 1'b0;
            issue_lane_r <= '0;
            elem_cnt_r   <= '0;
        end else if (go_accept_s) begin
            rd_addr_r    <= '0;
            issue_r      <= 1'b0;
            issue_lane_r <= '0;
            elem_cnt_r   <= '0;
        end else begin
            issue_r      <= issue_nxt_s;
            issue_lane_r <= lane_after_s;
            elem_cnt_r   <= cnt_after_s;
            if (issue_nxt_s) begin
                rd_addr_r <= ADDR_W'(cnt_after_s);
            end
        end
    end

    // Output-entry reservations: taken when a group starts, released when its word is pushed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resv_r <= 2'd0;
        end else begin
            resv_r <= resv_rel_s + {1'b0, (issue_nxt_s & group_start_s)};
        end
    end

    // Carry issue valid, lane and last-element flag alongside the buffer read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe_r  <= '0;
            last_pipe_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                lane_pipe_r[i] <= '0;
            end
        end else begin
            vld_pipe_r[0]  <= issue_r;
            last_pipe_r[0] <= last_issue_s;
            lane_pipe_r[0] <= issue_lane_r;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
                lane_pipe_r[i] <= lane_pipe_r[i-1];
            end
        end
    end

    // Capture returning elements into their lane; a completed word is pushed the next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pack_r      <= '0;
            push_pend_r <= 1'b0;
            push_last_r <= 1'b0;
        end else begin
            push_pend_r <= cap_s & (cap_lane_s == LAST_LANE);
            push_last_r <= cap_s & (cap_lane_s == LAST_LANE) & last_pipe_r[RD_LAT-1];
            if (cap_s) begin
                for (int k = 0; k < PACK; k++) begin
                    if (cap_lane_s == LANE_W'(k)) begin
                        pack_r[k*ELEM_W +: ELEM_W] <= rd_data;
                    end
                end
            end
        end
    end

    drain_word_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push_s),
        .push_data (pack_r),
        .push_last (push_last_r),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .out_data  (fifo_data_s),
        .out_last  (fifo_last_s)
    );

endmodule

// File: tb/tb_conv_result_drain_streamer.sv
// Self-checking bench: scenario table plus hand-written reset and full-size sequences,
// with expected words computed from the element ordering rule.
module tb_conv_result_drain_streamer;

    localparam int N_ELEM  = 64;
    localparam int N_WORDS = 8;
    localparam int PACK    = 8;
    localparam int BIG_WORDS = 4096;

    logic        clk = 1'b0;
    logic        resetn, go, acc_done, m_tready;
    logic        busy, acc_start, m_tvalid, m_tlast, drain_done;
    logic [31:0] rd_addr, m_tdata;
    logic [3:0]  rd_data;

    logic        go2, acc_done2, m_tready2;
    logic        busy2, acc_start2, m_tvalid2, m_tlast2, drain_done2;
    logic [31:0] rd_addr2, m_tdata2;
    logic [3:0]  rd_data2;

    always #5 clk = ~clk;

    conv_result_drain_streamer #(
        .NUM_ELEM(N_ELEM), .ELEM_W(4), .PACK(PACK), .ADDR_W(32), .RD_LAT(1)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .busy(busy), .acc_start(acc_start),
        .acc_done(acc_done), .rd_addr(rd_addr), .rd_data(rd_data), .m_tdata(m_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .drain_done(drain_done)
    );

    conv_result_drain_streamer dut_big (
        .clk(clk), .resetn(resetn), .go(go2), .busy(busy2), .acc_start(acc_start2),
        .acc_done(acc_done2), .rd_addr(rd_addr2), .rd_data(rd_data2), .m_tdata(m_tdata2),
        .m_tvalid(m_tvalid2), .m_tready(m_tready2), .m_tlast(m_tlast2), .drain_done(drain_done2)
    );

    // Result buffer model: registered read returning the low address nibble.
    always @(posedge clk) begin
        rd_data  <= rd_addr[3:0];
        rd_data2 <= rd_addr2[3:0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Word w holds elements w*PACK .. w*PACK+PACK-1, each equal to its index mod 16.
    function automatic logic [31:0] model_word(input int w);
        logic [31:0] r;
        r = 32'h0;
        for (int k = 0; k < PACK; k++) r[k*4 +: 4] = 4'((w * PACK + k) % 16);
        return r;
    endfunction

    int          hs_idx, acc_cnt, dd_cnt, start_cyc, last_hs_cyc;
    bit          done_seen, prev_stall, prev_last;
    logic [31:0] prev_data;
    int          ready_mode;

    // Stream monitor for the small instance.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
            hs_idx     = 0;
        end else begin
            if (acc_start) begin
                acc_cnt++;
                start_cyc = cyc;
            end
            check("rd_addr_max", 64'(rd_addr <= 32'd63), 64'd1);
            if (prev_stall) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_data", 64'(m_tdata), 64'(prev_data));
                check("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                check("word_data", 64'(m_tdata), 64'(model_word(hs_idx)));
                check("word_last", 64'(m_tlast), 64'(hs_idx == N_WORDS - 1));
                if (m_tlast) last_hs_cyc = cyc;
                hs_idx++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (drain_done) begin
                dd_cnt++;
                done_seen = 1'b1;
                check("done_busy_low", 64'(busy), 64'd0);
                check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
            end
        end
    end

    int hs2 = 0, acc2_cnt = 0, start2_cyc = -1, first_v2_cyc = -1;
    bit dd2_seen = 1'b0;

    // Stream monitor for the full-size instance.
    always @(negedge clk) begin
        if (resetn) begin
            if (acc_start2) begin
                acc2_cnt++;
                start2_cyc = cyc;
            end
            if (m_tvalid2 && first_v2_cyc < 0) first_v2_cyc = cyc;
            if (m_tvalid2 && m_tready2) begin
                check("big_data", 64'(m_tdata2), 64'(model_word(hs2)));
                check("big_last", 64'(m_tlast2), 64'(hs2 == BIG_WORDS - 1));
                hs2++;
            end
            if (drain_done2) dd2_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    endtask

    task automatic run_drain(input int mode, input int dly, input bit extra_go,
                             input int exp_words, input int exp_starts);
        int c;
        hs_idx = 0; acc_cnt = 0; dd_cnt = 0; done_seen = 1'b0;
        start_cyc = -1000; last_hs_cyc = -1000;
        ready_mode = mode;
        go = 1'b1;
        tick();
        go = 1'b0;
        c = 0;
        while (!done_seen && c < 3000) begin
            tick();
            c++;
            go = 1'b0;
            if (c == 1) check("rd_addr_restart", 64'(rd_addr), 64'd0);
            if (cyc >= start_cyc + dly) acc_done = 1'b1;
            if (extra_go && (c == 5 || c == dly + 12)) go = 1'b1;
            if (extra_go && cyc == last_hs_cyc + 1) go = 1'b1;
            if (mode == 2 && c == 60) begin
                check("stall_rd_addr", 64'(rd_addr), 64'd15);
                check("stall_tvalid", 64'(m_tvalid), 64'd1);
                check("stall_tdata", 64'(m_tdata), 64'h76543210);
                check("stall_no_words", 64'(hs_idx), 64'd0);
                ready_mode = 0;
            end
        end
        go = 1'b0;
        acc_done = 1'b0;
        if (!done_seen) check("drain_timeout", 64'd0, 64'd1);
        repeat (4) tick();
        check("word_count", 64'(hs_idx), 64'(exp_words));
        check("acc_start_pulses", 64'(acc_cnt), 64'(exp_starts));
        check("drain_done_pulses", 64'(dd_cnt), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int mode;       // 0 ready always, 1 random ready, 2 stalled then released
        int dly;        // cycles from acc_start to acc_done
        bit extra_go;   // extra go pulses in WAIT_DONE, DRAIN and DONE
        int exp_words;
        int exp_starts;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{mode: 0, dly: 20, extra_go: 1'b0, exp_words: N_WORDS, exp_starts: 1};
        tbl[1] = '{mode: 1, dly: 7,  extra_go: 1'b0, exp_words: N_WORDS, exp_starts: 1};
        tbl[2] = '{mode: 2, dly: 3,  extra_go: 1'b0, exp_words: N_WORDS, exp_starts: 1};
        tbl[3] = '{mode: 0, dly: 12, extra_go: 1'b1, exp_words: N_WORDS, exp_starts: 1};
        tbl[4] = '{mode: 1, dly: 0,  extra_go: 1'b0, exp_words: N_WORDS, exp_starts: 1};

        resetn = 1'b0; go = 1'b0; acc_done = 1'b0; m_tready = 1'b0; ready_mode = 2;
        go2 = 1'b0; acc_done2 = 1'b0; m_tready2 = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acc_start", 64'(acc_start), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_drain_done", 64'(drain_done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_drain(tbl[i].mode, tbl[i].dly, tbl[i].extra_go, tbl[i].exp_words,
                      tbl[i].exp_starts);
        end

        // Reset in the middle of a drain, after three accepted words.
        begin
            int c;
            hs_idx = 0; acc_cnt = 0; start_cyc = -1000; ready_mode = 0;
            go = 1'b1;
            tick();
            go = 1'b0;
            c = 0;
            while (hs_idx < 3 && c < 500) begin
                tick();
                c++;
                if (cyc >= start_cyc + 20) acc_done = 1'b1;
            end
            if (hs_idx < 3) check("mid_reset_timeout", 64'd0, 64'd1);
            resetn = 1'b0;
            #1;
            check("mrst_busy", 64'(busy), 64'd0);
            check("mrst_acc_start", 64'(acc_start), 64'd0);
            check("mrst_tvalid", 64'(m_tvalid), 64'd0);
            check("mrst_tlast", 64'(m_tlast), 64'd0);
            check("mrst_drain_done", 64'(drain_done), 64'd0);
            check("mrst_rd_addr", 64'(rd_addr), 64'd0);
            check("mrst_tdata", 64'(m_tdata), 64'd0);
            acc_done = 1'b0;
            tick();
            resetn = 1'b1;
            tick();
            run_drain(0, 20, 1'b0, N_WORDS, 1);
        end

        // Full-size instance, acc_done already high when go arrives.
        begin
            int c;
            acc_done2 = 1'b1;
            m_tready2 = 1'b1;
            go2 = 1'b1;
            tick();
            go2 = 1'b0;
            c = 0;
            while (!dd2_seen && c < 34000) begin
                tick();
                c++;
            end
            if (!dd2_seen) check("big_timeout", 64'd0, 64'd1);
            check("big_word_count", 64'(hs2), 64'(BIG_WORDS));
            check("big_acc_start_pulses", 64'(acc2_cnt), 64'd1);
            check("big_first_valid_latency", 64'(first_v2_cyc - start2_cyc), 64'd12);
            acc_done2 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
